// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: opcodes, ALUOp encoding, multi-cycle state
// encodings and datapath mux select codes.
package mips_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALUOP_RFUNCT = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ    = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALUOP_BNE    = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI   = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI   = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI    = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALUOP_XORI   = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 4'b0111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CL_MEM,
        CL_RTYPE,
        CL_BR,
        CL_IMM,
        CL_JMP,
        CL_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/mc_op_class.sv
// Opcode classifier: groups the opcode for DECODE branching and supplies the
// immediate-form ALUOp and sign-extension choice.
module mc_op_class
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    op_i,
    output op_class_e          op_class_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               sign_ext_o
);

    always_comb begin
        op_class_o = CL_ILLEGAL;
        alu_op_o   = ALUOP_ADD;
        sign_ext_o = 1'b0;
        case (op_i)
            OP_LW, OP_SW:  op_class_o = CL_MEM;
            OP_RTYPE:      op_class_o = CL_RTYPE;
            OP_BEQ:        begin op_class_o = CL_BR; alu_op_o = ALUOP_BEQ; end
            OP_BNE:        begin op_class_o = CL_BR; alu_op_o = ALUOP_BNE; end
            OP_J, OP_JAL:  op_class_o = CL_JMP;
            OP_ADDI:       begin op_class_o = CL_IMM; alu_op_o = ALUOP_ADDI; sign_ext_o = 1'b1; end
            OP_ADDIU:      begin op_class_o = CL_IMM; alu_op_o = ALUOP_ADDI; end
            OP_ANDI:       begin op_class_o = CL_IMM; alu_op_o = ALUOP_ANDI; end
            OP_ORI:        begin op_class_o = CL_IMM; alu_op_o = ALUOP_ORI;  end
            OP_XORI:       begin op_class_o = CL_IMM; alu_op_o = ALUOP_XORI; end
            // lui shifts the immediate into the upper half; extension kind is irrelevant but kept signed
            OP_LUI:        begin op_class_o = CL_IMM; alu_op_o = ALUOP_LUI;  sign_ext_o = 1'b1; end
            default:       op_class_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/memory/writeback over a shared
// ALU and memory port. Optional retired-instruction counter: MC_INSTR_COUNT_EN.
module mc_control
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Op,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               SignExtend,
    output logic               pcreg,
    output logic               PCWrite,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal_op,
    output logic [3:0]         state_o,
    output logic [31:0]        instr_retired
);

    // state  | meaning
    // FETCH  | read instruction, PC+4 -> PC on mem_ready
    // DECODE | branch target -> ALUOut, dispatch on opcode class
    // MEMADR | base + offset for lw/sw
    // MEMRD  | load read, wait on mem_ready
    // MEMWB  | load data -> rt
    // MEMWR  | store write, wait on mem_ready
    // EXEC   | R-type ALU operation
    // ALUWB  | ALU result -> rd
    // IEXEC  | immediate ALU operation
    // IWB    | ALU result -> rt
    // BRANCH | compare, conditional PC update
    // JUMP   | jump target -> PC (jal also links $31)

    state_e             state_q;
    op_class_e          op_class;
    logic [ALUOP_W-1:0] imm_alu_op;
    logic               imm_sign_ext;

    mc_op_class u_op_class (
        .op_i       (Op),
        .op_class_o (op_class),
        .alu_op_o   (imm_alu_op),
        .sign_ext_o (imm_sign_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op_class)
                        CL_MEM:   state_q <= S_MEMADR;
                        CL_RTYPE: state_q <= S_EXEC;
                        CL_BR:    state_q <= S_BRANCH;
                        CL_IMM:   state_q <= S_IEXEC;
                        CL_JMP:   state_q <= S_JUMP;
                        default:  state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_IEXEC:  state_q <= S_IWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        SignExtend = 1'b0;
        pcreg      = 1'b0;
        PCWrite    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSource   = PCSRC_ALU;
        ALUOp      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                SignExtend = 1'b1;
                illegal_op = (op_class == CL_ILLEGAL);
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                SignExtend = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RFUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = imm_alu_op;
                SignExtend = imm_sign_ext;
            end
            S_IWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = imm_alu_op;
                PCSource = PCSRC_ALUOUT;
                PCWrite  = (Op == OP_BEQ) ? Zero : ~Zero;
            end
            S_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCWrite  = 1'b1;
                pcreg    = (Op == OP_JAL);
                RegWrite = (Op == OP_JAL);
            end
            default: ;
        endcase
        // reset overrides the decode so no write escapes while the sequencer is restarting
        if (reset) begin
            IRWrite    = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            PCWrite    = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] retired_q;
    logic        retire;

    always_comb begin
        case (state_q)
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       retired_q <= 32'd0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign instr_retired = retired_q;
`else
    assign instr_retired = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: random instruction streams expanded into
// expected per-cycle control vectors, compared every cycle.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op;
    logic        Zero;
    logic        mem_ready;
    logic        IorD, IRWrite, MemRead, MemWrite, RegDst, MemtoReg, RegWrite;
    logic        ALUSrcA, SignExtend, pcreg, PCWrite, illegal_op;
    logic [1:0]  ALUSrcB, PCSource;
    logic [3:0]  ALUOp, state_o;
    logic [31:0] instr_retired;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .SignExtend(SignExtend), .pcreg(pcreg), .PCWrite(PCWrite), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op), .state_o(state_o),
        .instr_retired(instr_retired)
    );

`ifdef MC_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // control vector: {IorD,IRWrite,MemRead,MemWrite,RegDst,MemtoReg,RegWrite,
    //                  ALUSrcA,SignExtend,pcreg,PCWrite,ALUSrcB,PCSource,ALUOp,illegal_op}
    localparam logic [19:0] C_IORD = 20'h80000, C_IRW = 20'h40000, C_MRD = 20'h20000;
    localparam logic [19:0] C_MWR = 20'h10000, C_RDST = 20'h08000, C_M2R = 20'h04000;
    localparam logic [19:0] C_RW = 20'h02000, C_SRCA = 20'h01000, C_SX = 20'h00800;
    localparam logic [19:0] C_PCREG = 20'h00400, C_PCW = 20'h00200, C_ILL = 20'h00001;
    localparam logic [19:0] STROBES = C_IRW | C_MRD | C_MWR | C_RW | C_PCW | C_ILL;

    wire [19:0] act = {IorD, IRWrite, MemRead, MemWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, SignExtend, pcreg, PCWrite, ALUSrcB, PCSource, ALUOp, illegal_op};

    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [19:0] ctl;
        bit          retire;
    } cyc_t;

    cyc_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    function automatic logic [19:0] sb(input logic [1:0] v); return {11'b0, v, 7'b0}; endfunction
    function automatic logic [19:0] ps(input logic [1:0] v); return {13'b0, v, 5'b0}; endfunction
    function automatic logic [19:0] ao(input logic [3:0] v); return {15'b0, v, 1'b0}; endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic [5:0] op,
                        input logic zero, input logic [19:0] ctl, input bit ret);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.op = op; c.zero = zero; c.ctl = ctl; c.retire = ret;
        q.push_back(c);
    endtask

    // Expand one instruction into its cycle-by-cycle expectations.
    task automatic gen_instr(input logic [5:0] op, input logic zero, input int fw, input int mw);
        logic [3:0]  a;
        logic [19:0] sx;
        bit          taken;
        for (int i = 0; i < fw; i++) push(4'd0, 1'b0, op, zero, C_MRD | sb(2'b01), 0);
        push(4'd0, 1'b1, op, zero, C_MRD | C_IRW | C_PCW | sb(2'b01), 0);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111:
                push(4'd1, 1'($urandom), op, zero, sb(2'b11) | C_SX, 0);
            default: begin
                push(4'd1, 1'($urandom), op, zero, sb(2'b11) | C_SX | C_ILL, 0);
                return;
            end
        endcase
        case (op)
            6'b100011: begin
                push(4'd2, 1'($urandom), op, zero, C_SRCA | sb(2'b10) | C_SX, 0);
                for (int i = 0; i < mw; i++) push(4'd3, 1'b0, op, zero, C_MRD | C_IORD, 0);
                push(4'd3, 1'b1, op, zero, C_MRD | C_IORD, 0);
                push(4'd4, 1'($urandom), op, zero, C_M2R | C_RW, 1);
            end
            6'b101011: begin
                push(4'd2, 1'($urandom), op, zero, C_SRCA | sb(2'b10) | C_SX, 0);
                for (int i = 0; i < mw; i++) push(4'd5, 1'b0, op, zero, C_MWR | C_IORD, 0);
                push(4'd5, 1'b1, op, zero, C_MWR | C_IORD, 1);
            end
            6'b000000: begin
                push(4'd6, 1'($urandom), op, zero, C_SRCA | ao(4'b1000), 0);
                push(4'd7, 1'($urandom), op, zero, C_RDST | C_RW, 1);
            end
            6'b000100, 6'b000101: begin
                taken = (op == 6'b000100) ? zero : !zero;
                push(4'd10, 1'($urandom), op, zero,
                     C_SRCA | ps(2'b01) | ao((op == 6'b000100) ? 4'b0100 : 4'b0110) |
                     (taken ? C_PCW : 20'h0), 1);
            end
            6'b000010, 6'b000011:
                push(4'd11, 1'($urandom), op, zero,
                     ps(2'b10) | C_PCW | ((op == 6'b000011) ? (C_PCREG | C_RW) : 20'h0), 1);
            default: begin
                case (op)
                    6'b001000: begin a = 4'b0001; sx = C_SX; end
                    6'b001001: begin a = 4'b0001; sx = 20'h0; end
                    6'b001100: begin a = 4'b0010; sx = 20'h0; end
                    6'b001101: begin a = 4'b0011; sx = 20'h0; end
                    6'b001110: begin a = 4'b0101; sx = 20'h0; end
                    default:   begin a = 4'b0111; sx = C_SX; end
                endcase
                push(4'd8, 1'($urandom), op, zero, C_SRCA | sb(2'b10) | ao(a) | sx, 0);
                push(4'd9, 1'($urandom), op, zero, C_RW, 1);
            end
        endcase
    endtask

    // Compare process: entered at posedge+1, drives a cycle, checks at negedge.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            Op = c.op; Zero = c.zero; mem_ready = c.rdy;
            @(negedge clk);
            chk("state", {28'b0, state_o}, {28'b0, c.st});
            chk("ctl", {12'b0, act}, {12'b0, c.ctl});
            chk("retired", instr_retired, CNT_EN ? exp_cnt : 32'd0);
            @(posedge clk); #1;
            if (c.retire) exp_cnt++;
        end
    endtask

    localparam logic [5:0] OPS [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                        6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3f};

    initial begin
        reset = 1'b1; Op = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {28'b0, state_o}, 32'd0);
        chk("reset_strobes", {12'b0, act & STROBES}, 32'd0);
        chk("reset_retired", instr_retired, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed, with model length pinned to the documented cycle counts
        gen_instr(6'h00, 1'b0, 0, 0); chk("len_add", q.size(), 4);  run_queue();
        chk("add_counted", instr_retired, CNT_EN ? 32'd1 : 32'd0);
        gen_instr(6'h23, 1'b0, 0, 2); chk("len_lw_wait2", q.size(), 7); run_queue();
        gen_instr(6'h2b, 1'b0, 0, 0); chk("len_sw", q.size(), 4);  run_queue();
        gen_instr(6'h04, 1'b1, 0, 0); chk("len_beq", q.size(), 3); run_queue();
        gen_instr(6'h05, 1'b1, 0, 0); chk("len_bne", q.size(), 3); run_queue();
        gen_instr(6'h03, 1'b0, 0, 0); chk("len_jal", q.size(), 3); run_queue();
        gen_instr(6'h02, 1'b0, 0, 0); chk("len_j", q.size(), 3);   run_queue();
        gen_instr(6'h3f, 1'b0, 0, 0); chk("len_illegal", q.size(), 2); run_queue();
        chk("directed_count", instr_retired, CNT_EN ? 32'd7 : 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 13)];
            gen_instr(op, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
            run_queue();
        end

        // reset during a store wait
        gen_instr(6'h2b, 1'b0, 1, 3);
        void'(q.pop_back());
        run_queue();
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", {12'b0, act & STROBES}, 32'd0);
        chk("rst_mid_state_hold", {28'b0, state_o}, 32'd5);
        @(posedge clk); #1;
        chk("rst_mid_state", {28'b0, state_o}, 32'd0);
        chk("rst_mid_retired", instr_retired, 32'd0);
        exp_cnt = 0;
        reset = 1'b0;

        for (int n = 0; n < 40; n++) begin
            gen_instr(OPS[$urandom_range(0, 13)], 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 2));
            run_queue();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle sequencer for the MIPS datapath: replaces per-instruction single-cycle decode with an FSM stepping fetch/decode/execute/memory/writeback over one shared ALU and one shared memory port. It sits beside the datapath, takes opcode (IR[31:26]), ALU Zero and a memory ready handshake, and drives every mux select and write strobe each cycle. Opcode set and ALUOp encoding are the codebase's existing ones.

Parameters:
- OP_W, 6, opcode width
- ALUOP_W, 4, ALUOp width (existing encoding: 0000 add, 1000 R-funct, 0100 beq-sub, 0110 bne-sub, 0001 addi, 0010 andi, 0011 ori, 0101 xori, 0111 lui)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Op  in  6  opcode from IR, stable from DECODE until FETCH
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- IorD, IRWrite, MemRead, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, SignExtend, pcreg, PCWrite  out  1 each  datapath controls (pcreg: jal writes PC+4 to $31)
- ALUSrcB  out  2  00 reg, 01 const 4, 10 ext imm, 11 ext imm<<2
- PCSource  out  2  00 ALU, 01 ALUOut (branch target), 10 jump target
- ALUOp  out  4  existing encoding
- illegal_op  out  1  one-cycle pulse on undecoded opcode
- state_o  out  4  current state (debug)
- instr_retired  out  32  see Optional Feature

Behaviour:
- State register 4 bits; outputs are combinational decode of state (plus Op/Zero where stated). Unlisted outputs 0; ALUOp defaults 0000.
- While reset=1: all strobes (IRWrite, MemRead, MemWrite, RegWrite, PCWrite) forced 0; next edge state=FETCH(0); illegal_op=0; counter=0. Reset mid-instruction abandons it; mem_ready ignored.
- FETCH(0): MemRead=1, IorD=0, ALUSrcB=01, PCSource=00; hold until mem_ready; in the mem_ready cycle IRWrite=1, PCWrite=1, ->DECODE.
- DECODE(1): ALUSrcB=11, SignExtend=1 (branch target to ALUOut). lw/sw->MEMADR; R(000000)->EXEC; beq/bne->BRANCH; addi/addiu/andi/ori/xori/lui->IEXEC; j/jal->JUMP; other ->FETCH with illegal_op=1, no writes.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, SignExtend=1; lw->MEMRD, sw->MEMWR.
- MEMRD(3): MemRead=1, IorD=1; hold until mem_ready ->MEMWB.
- MEMWB(4): MemtoReg=1, RegWrite=1, RegDst=0 ->FETCH.
- MEMWR(5): MemWrite=1, IorD=1; hold until mem_ready ->FETCH. MemWrite stays high every wait cycle.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=1000 ->ALUWB(7): RegDst=1, RegWrite=1 ->FETCH.
- IEXEC(8): ALUSrcA=1, ALUSrcB=10, ALUOp per opcode; SignExtend=1 for addi/lui, 0 for addiu/andi/ori/xori ->IWB(9): RegDst=0, RegWrite=1 ->FETCH.
- BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALUOp 0100(beq)/0110(bne), PCSource=01; PCWrite = beq?Zero:~Zero ->FETCH.
- JUMP(11): PCSource=10, PCWrite=1; jal additionally pcreg=1, RegWrite=1 ->FETCH.
- Unused encodings 12-15 ->FETCH next edge, no strobes.
- CPI: R/imm 4, lw 5, sw 4, branch/jump 3 (mem_ready=1 always); each mem_ready=0 cycle adds 1.

Optional Feature:
- MC_INSTR_COUNT_EN: defined -> instr_retired counts completed instructions, +1 on the exit edge of MEMWB, MEMWR (with mem_ready), ALUWB, IWB, BRANCH (taken or not), JUMP; illegal opcodes not counted; wraps 0xFFFFFFFF->0; cleared by reset. Undefined -> no counter register, instr_retired tied to 0.

Decomposition:
- Package mips_ctrl_pkg: opcode constants, ALUOp constants, state encodings, ALUSrcB/PCSource select constants; later shared with the single-cycle decoder.
- One sub-module mc_op_class: combinational Op -> class (MEM, RTYPE, BR, IMM, JMP, ILLEGAL) plus per-opcode ALUOp/SignExtend; FSM uses the class for DECODE branching.

Test Plan:
- add (Op=000000), mem_ready=1: states 0,1,6,7,0; RegWrite=1 only in ALUWB with RegDst=1; counter +1.
- lw with mem_ready low 2 cycles in MEMRD: MemRead/IorD held 3 cycles, MEMWB RegWrite=1 MemtoReg=1; total 7 cycles.
- beq Zero=1 -> PCWrite=1, PCSource=01; bne Zero=1 -> PCWrite=0; both 3 cycles, counted.
- jal (000011): JUMP asserts PCWrite=1, PCSource=10, pcreg=1, RegWrite=1; j asserts pcreg=0, RegWrite=0.
- Op=111111: DECODE pulses illegal_op=1, returns to FETCH, no RegWrite/MemWrite, counter unchanged.
- reset asserted during MEMWR wait: strobes 0 immediately, state_o=0 next edge, instr_retired=0.
